// File: rtl/ysyx_040066_mul_issue.sv
// Issue/retire controller for the 2-stage booth/wallace multiplier: feeds operands,
// drives the shared freeze line and carries op tag/valid beside the multiplier pipe.
module ysyx_040066_mul_issue #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_src1,
    input  logic [63:0]      in_src2,
    input  logic [1:0]       in_op,
    input  logic             in_is_w,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy,
    output logic             mul_block,
    output logic [63:0]      mul_src1,
    output logic [63:0]      mul_src2,
    output logic [1:0]       mul_aluctr_in,
    output logic [1:0]       mul_aluctr,
    output logic             mul_is_w,
    input  logic [63:0]      mul_result
);

    logic             vld_p1;
    logic             vld_p2;
    logic [1:0]       op_p1;
    logic             w_p1;
    logic [TAG_W-1:0] tag_p1;
    logic [TAG_W-1:0] tag_p2;
    logic             stall;
    logic             fire;

    // A result waiting on WB freezes the whole multiplier; flush always overrides it.
    assign stall     = vld_p2 & ~out_ready & ~flush;
    assign fire      = in_valid & ~stall & ~flush;
    assign in_ready  = ~stall;
    assign mul_block = stall;

    // Stage 0: operands gated to zero when nothing issues, so the array stays quiet.
    assign mul_src1      = fire ? in_src1 : 64'd0;
    assign mul_src2      = fire ? in_src2 : 64'd0;
    assign mul_aluctr_in = fire ? in_op : 2'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            op_p1  <= 2'd0;
            w_p1   <= 1'b0;
            tag_p1 <= '0;
            tag_p2 <= '0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (!stall) begin
            vld_p1 <= fire;
            op_p1  <= in_op;
            w_p1   <= in_is_w;
            tag_p1 <= in_tag;
            vld_p2 <= vld_p1;
            tag_p2 <= tag_p1;
        end
    end

    // Stage 1: controls for the multiplier's second (clk1) stage.
    assign mul_aluctr = op_p1;
    assign mul_is_w   = w_p1;

    // Stage 2: retire.
    assign out_valid  = vld_p2 & ~flush;
    assign out_tag    = tag_p2;
    assign out_result = mul_result;
    assign busy       = vld_p1 | vld_p2;

endmodule

// File: tb/tb_ysyx_040066_mul_issue.sv
// Bench for ysyx_040066_mul_issue with a behavioural 2-stage multiplier stand-in.
module tb_ysyx_040066_mul_issue;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_src1;
    logic [63:0]      in_src2;
    logic [1:0]       in_op;
    logic             in_is_w;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;
    logic             mul_block;
    logic [63:0]      mul_src1;
    logic [63:0]      mul_src2;
    logic [1:0]       mul_aluctr_in;
    logic [1:0]       mul_aluctr;
    logic             mul_is_w;
    logic [63:0]      mul_result;

    int checks = 0;
    int errors = 0;

    ysyx_040066_mul_issue #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_src1(in_src1), .in_src2(in_src2),
        .in_op(in_op), .in_is_w(in_is_w), .in_tag(in_tag), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .busy(busy), .mul_block(mul_block),
        .mul_src1(mul_src1), .mul_src2(mul_src2), .mul_aluctr_in(mul_aluctr_in),
        .mul_aluctr(mul_aluctr), .mul_is_w(mul_is_w), .mul_result(mul_result)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: signedness latched with operands at clk0, hi/lo and W select at clk1.
    logic [63:0] m_a, m_b;
    logic [1:0]  m_sgn;

    function automatic logic [63:0] stub_mul(input logic [63:0] a, input logic [63:0] b,
                                             input logic [1:0] sgn, input logic [1:0] sel,
                                             input logic is_w);
        logic [127:0] xa, xb, p;
        xa = (sgn != 2'b11) ? {{64{a[63]}}, a} : {64'd0, a};
        xb = (sgn == 2'b00 || sgn == 2'b01) ? {{64{b[63]}}, b} : {64'd0, b};
        p  = xa * xb;
        if (sel == 2'b00) return is_w ? {{32{p[31]}}, p[31:0]} : p[63:0];
        return p[127:64];
    endfunction

    always @(posedge clk) begin
        if (!mul_block) begin
            m_a        <= mul_src1;
            m_b        <= mul_src2;
            m_sgn      <= mul_aluctr_in;
            mul_result <= stub_mul(m_a, m_b, m_sgn, mul_aluctr, mul_is_w);
        end
    end

    // Reference: unsigned product with sign corrections of the high half.
    function automatic logic [63:0] ref_mul(input logic [1:0] op, input logic is_w,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [127:0] pu;
        logic [63:0]  hi;
        pu = {64'd0, a} * {64'd0, b};
        hi = pu[127:64];
        case (op)
            2'b00:   return is_w ? {{32{pu[31]}}, pu[31:0]} : pu[63:0];
            2'b01:   return hi - (a[63] ? b : 64'd0) - (b[63] ? a : 64'd0);
            2'b10:   return hi - (a[63] ? b : 64'd0);
            default: return hi;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        in_valid = 1'b0; in_src1 = '0; in_src2 = '0; in_op = '0; in_is_w = 1'b0;
        in_tag = '0; flush = 1'b0; out_ready = 1'b1;
    endtask

    task automatic present(input logic [1:0] op, input logic w, input logic [63:0] a,
                           input logic [63:0] b, input logic [TAG_W-1:0] t);
        in_valid = 1'b1; in_op = op; in_is_w = w; in_src1 = a; in_src2 = b; in_tag = t;
    endtask

    task automatic run_single(input logic [1:0] op, input logic w, input logic [63:0] a,
                              input logic [63:0] b, input logic [TAG_W-1:0] t,
                              output logic [63:0] res, output logic [TAG_W-1:0] otag,
                              output int lat);
        res = '0; otag = '0; lat = -1;
        present(op, w, a, b, t);
        @(negedge clk);
        tick;
        idle;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                lat = i; res = out_result; otag = out_tag;
                break;
            end
            tick;
        end
        tick;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (mul_block !== 1'b0) begin errors++; $display("FAIL reset_mul_block got %b want 0", mul_block); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (mul_aluctr !== 2'd0) begin errors++; $display("FAIL reset_mul_aluctr got %0d want 0", mul_aluctr); end
        checks++; if (mul_is_w !== 1'b0) begin errors++; $display("FAIL reset_mul_is_w got %b want 0", mul_is_w); end
        checks++; if (out_tag !== '0) begin errors++; $display("FAIL reset_out_tag got %0d want 0", out_tag); end
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_basic;
        logic [63:0] r; logic [TAG_W-1:0] t; int lat;
        run_single(2'b00, 1'b0, 64'd3, 64'd5, 5'd7, r, t, lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL basic_latency got %0d want 2", lat); end
        checks++; if (r !== 64'd15) begin errors++; $display("FAIL basic_result got %0h want f", r); end
        checks++; if (t !== 5'd7) begin errors++; $display("FAIL basic_tag got %0d want 7", t); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_out_valid_after got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b want 0", busy); end
        tick;
    endtask

    task automatic test_mulh;
        logic [63:0] r; logic [TAG_W-1:0] t; int lat;
        run_single(2'b01, 1'b0, '1, '1, 5'd1, r, t, lat);
        checks++; if (r !== 64'd0) begin errors++; $display("FAIL mulh_m1 got %0h want 0", r); end
        run_single(2'b11, 1'b0, '1, '1, 5'd2, r, t, lat);
        checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL mulhu_m1 got %0h want fffffffffffffffe", r); end
        run_single(2'b10, 1'b0, '1, '1, 5'd3, r, t, lat);
        checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL mulhsu_m1 got %0h want ffffffffffffffff", r); end
    endtask

    task automatic test_mulw;
        logic [63:0] r; logic [TAG_W-1:0] t; int lat;
        run_single(2'b00, 1'b1, 64'h7FFF_FFFF, 64'd2, 5'd4, r, t, lat);
        checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL mulw got %0h want fffffffffffffffe", r); end
        run_single(2'b00, 1'b0, 64'h7FFF_FFFF, 64'd2, 5'd5, r, t, lat);
        checks++; if (r !== 64'hFFFF_FFFE) begin errors++; $display("FAIL mul_not_w got %0h want fffffffe", r); end
    endtask

    task automatic test_back_to_back;
        logic       exp_ov[9]  = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
        logic       exp_blk[9] = '{0, 0, 1, 1, 1, 0, 0, 0, 0};
        int         exp_tg[9]  = '{0, 0, 1, 1, 1, 1, 2, 3, 0};
        logic [63:0] e;
        for (int c = 0; c < 9; c++) begin
            idle;
            out_ready = !(c >= 2 && c <= 4);
            if (c == 0) present(2'b00, 1'b0, 64'd10, 64'd11, 5'd1);
            else if (c == 1) present(2'b00, 1'b0, 64'd12, 64'd13, 5'd2);
            else if (c <= 5) present(2'b00, 1'b0, 64'd14, 64'd15, 5'd3);
            @(negedge clk);
            checks++; if (out_valid !== exp_ov[c]) begin errors++; $display("FAIL b2b_out_valid c%0d got %b want %b", c, out_valid, exp_ov[c]); end
            checks++; if (mul_block !== exp_blk[c]) begin errors++; $display("FAIL b2b_mul_block c%0d got %b want %b", c, mul_block, exp_blk[c]); end
            checks++; if (in_ready !== !exp_blk[c]) begin errors++; $display("FAIL b2b_in_ready c%0d got %b want %b", c, in_ready, !exp_blk[c]); end
            if (exp_ov[c]) begin
                e = ref_mul(2'b00, 1'b0, 64'(8 + 2 * exp_tg[c]), 64'(9 + 2 * exp_tg[c]));
                checks++; if (out_tag !== TAG_W'(exp_tg[c])) begin errors++; $display("FAIL b2b_tag c%0d got %0d want %0d", c, out_tag, exp_tg[c]); end
                checks++; if (out_result !== e) begin errors++; $display("FAIL b2b_result c%0d got %0h want %0h", c, out_result, e); end
            end
            if (c == 3) begin
                checks++; if (mul_src1 !== 64'd0) begin errors++; $display("FAIL b2b_src_gated got %0h want 0", mul_src1); end
            end
            if (c == 8) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end got %b want 0", busy); end
            end
            tick;
        end
    endtask

    task automatic test_flush;
        for (int c = 0; c < 7; c++) begin
            idle;
            if (c == 0) present(2'b00, 1'b0, 64'd6, 64'd7, 5'd9);
            if (c == 1) present(2'b00, 1'b0, 64'd8, 64'd9, 5'd10);
            if (c == 2) begin
                present(2'b00, 1'b0, 64'd20, 64'd21, 5'd11);
                flush = 1'b1; out_ready = 1'b0;
            end
            if (c == 3) present(2'b00, 1'b0, 64'd5, 64'd6, 5'd12);
            @(negedge clk);
            if (c == 2) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b want 0", out_valid); end
                checks++; if (mul_block !== 1'b0) begin errors++; $display("FAIL flush_mul_block got %b want 0", mul_block); end
                checks++; if (mul_src1 !== 64'd0) begin errors++; $display("FAIL flush_no_fire got %0h want 0", mul_src1); end
            end
            if (c == 3 || c == 4 || c == 6) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_after_out_valid c%0d got %b want 0", c, out_valid); end
            end
            if (c == 3 || c == 6) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy c%0d got %b want 0", c, busy); end
            end
            if (c == 5) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_next_valid got %b want 1", out_valid); end
                checks++; if (out_tag !== 5'd12) begin errors++; $display("FAIL flush_next_tag got %0d want 12", out_tag); end
                checks++; if (out_result !== 64'd30) begin errors++; $display("FAIL flush_next_result got %0h want 1e", out_result); end
            end
            tick;
        end
    endtask

    task automatic test_reset_midop;
        idle;
        present(2'b11, 1'b1, 64'd100, 64'd200, 5'd21);
        tick;
        present(2'b11, 1'b1, 64'd300, 64'd400, 5'd22);
        tick;
        idle;
        out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
        checks++; if (mul_block !== 1'b0) begin errors++; $display("FAIL rstmid_mul_block got %b want 0", mul_block); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
        checks++; if (mul_aluctr !== 2'd0) begin errors++; $display("FAIL rstmid_mul_aluctr got %0d want 0", mul_aluctr); end
        checks++; if (mul_is_w !== 1'b0) begin errors++; $display("FAIL rstmid_mul_is_w got %b want 0", mul_is_w); end
        checks++; if (out_tag !== '0) begin errors++; $display("FAIL rstmid_out_tag got %0d want 0", out_tag); end
        tick;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale_valid c%0d got %b want 0", c, out_valid); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_stale_busy c%0d got %b want 0", c, busy); end
            tick;
        end
    endtask

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [63:0]      res;
        int               age;
    } ent_t;

    task automatic test_random;
        ent_t q[$];
        ent_t e;
        logic vis, exp_ov, stall_e;
        for (int c = 0; c < 400; c++) begin
            idle;
            if (c < 390) begin
                in_valid  = ($urandom_range(0, 9) < 7);
                out_ready = ($urandom_range(0, 9) < 6);
                flush     = ($urandom_range(0, 31) == 0);
                in_op     = 2'($urandom_range(0, 3));
                in_is_w   = ($urandom_range(0, 3) == 0);
                in_tag    = TAG_W'($urandom);
                in_src1   = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 20)) : {$urandom, $urandom};
                in_src2   = ($urandom_range(0, 3) == 0) ? ~64'($urandom_range(0, 20)) : {$urandom, $urandom};
            end
            @(negedge clk);
            vis     = (q.size() > 0) && (q[0].age >= 2);
            exp_ov  = vis && !flush;
            stall_e = vis && !out_ready && !flush;
            checks++; if (out_valid !== exp_ov) begin errors++; $display("FAIL rnd_out_valid c%0d got %b want %b", c, out_valid, exp_ov); end
            checks++; if (in_ready !== !stall_e) begin errors++; $display("FAIL rnd_in_ready c%0d got %b want %b", c, in_ready, !stall_e); end
            checks++; if (mul_block !== stall_e) begin errors++; $display("FAIL rnd_mul_block c%0d got %b want %b", c, mul_block, stall_e); end
            checks++; if (busy !== (q.size() > 0)) begin errors++; $display("FAIL rnd_busy c%0d got %b want %b", c, busy, q.size() > 0); end
            if (exp_ov) begin
                checks++; if (out_tag !== q[0].tag) begin errors++; $display("FAIL rnd_tag c%0d got %0d want %0d", c, out_tag, q[0].tag); end
                checks++; if (out_result !== q[0].res) begin errors++; $display("FAIL rnd_result c%0d got %0h want %0h", c, out_result, q[0].res); end
            end
            if (flush) begin
                q.delete();
            end else if (!stall_e) begin
                if (vis && out_ready) void'(q.pop_front());
                for (int i = 0; i < q.size(); i++) begin
                    e = q[i]; e.age++; q[i] = e;
                end
                if (in_valid) begin
                    e.tag = in_tag; e.res = ref_mul(in_op, in_is_w, in_src1, in_src2); e.age = 1;
                    q.push_back(e);
                end
            end
            tick;
        end
        @(negedge clk);
        checks++; if (q.size() != 0 || busy !== 1'b0) begin errors++; $display("FAIL rnd_drain pending %0d busy %b want 0 0", q.size(), busy); end
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        test_reset;
        test_basic;
        test_mulh;
        test_mulw;
        test_back_to_back;
        test_flush;
        test_reset_midop;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
